uart_cmd_sequencer: RTL and testbench
=====================================

# uart_cmd_sequencer

Byte-level command controller between the UART receiver and the internal register bus. It parses framed command packets from received bytes and sequences them into register write strobes or register read strobes. Read data is returned through the UART transmitter with busy handshaking. A single controller owns the register bus on behalf of the serial host and serializes all accesses.

## Interface
Parameters:
- ADDR_W, 6, register address width; taken from cmd byte bits [ADDR_W-1:0], ADDR_W ≤ 7
- RD_LAT, 1, cycles from reg_read pulse to valid reg_rdata; legal range 1..4

Ports:
- clk  in  1  system clock, single domain
- rst_n  in  1  asynchronous, active-low reset
- rx_data_ready  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- rx_endofpacket  in  1  one-cycle pulse, receiver line went idle
- reg_addr  out  ADDR_W  register address of current command
- reg_idx  out  8  byte index within current command, 0-based
- reg_wdata  out  8  write data
- reg_write  out  1  one-cycle write strobe
- reg_read  out  1  one-cycle read strobe
- reg_rdata  in  8  read data, valid RD_LAT cycles after reg_read
- tx_data  out  8  byte to transmit
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  transmitter busy; may rise one cycle after tx_start
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse on protocol error

## Operation
- Packet format: CMD byte, LEN byte, then payload.
  - CMD[7]: 1 = read, 0 = write. CMD[6]: reserved, ignored. CMD[ADDR_W-1:0]: address.
  - LEN: byte count 0..255. LEN = 0 completes with no bus or TX activity.
- States and transitions:
  - IDLE: rx byte → latch reg_addr and direction → LEN.
  - LEN: rx byte → count := byte, reg_idx := 0. If count = 0 → IDLE; else write → WDATA, read → RD_REQ.
  - WDATA: each rx byte → reg_write pulse with reg_wdata = byte, then count−1 and reg_idx+1. Leave to IDLE after the last byte.
  - RD_REQ: reg_read pulse for one cycle → RD_WAIT.
  - RD_WAIT: wait RD_LAT cycles, capture reg_rdata into tx_data → TX_WAIT.
  - TX_WAIT: when tx_busy is low, pulse tx_start → TX_GUARD.
  - TX_GUARD: one cycle with tx_busy ignored. Then count−1 and reg_idx+1; if count reaches 0 → IDLE, else → RD_REQ.
- Any rx byte arriving in RD_REQ, RD_WAIT, TX_WAIT or TX_GUARD is dropped and pulses err. The state is unchanged.
- reg_addr holds its value for the whole packet; there is no address auto-increment. reg_idx wraps 255 → 0, which is unreachable because LEN ≤ 255.
- Reset values: all outputs 0, state IDLE, count 0.
- Reset asserted mid-operation returns to IDLE immediately. Strobes deassert asynchronously, and no partial TX is retried.

## Timing
- rx_data_ready in WDATA → reg_write high on the next clk edge (1-cycle latency), for exactly 1 cycle.
- Read path, per byte: reg_read at cycle T; rdata captured at T+RD_LAT; tx_start no earlier than T+RD_LAT+1, and later if tx_busy is high.
- Minimum spacing between consecutive tx_start pulses is 3 cycles plus RD_LAT.
- rx_data_ready and rx_endofpacket in the same cycle: the data byte is processed and endofpacket is ignored.

## Configuration
- UART_CMD_TIMEOUT_EN defined:
  - rx_endofpacket while in LEN or WDATA with count ≠ 0 aborts the command. State → IDLE, err pulses, no further strobes.
  - rx_endofpacket in IDLE or in the read states is ignored.
- UART_CMD_TIMEOUT_EN undefined:
  - rx_endofpacket is ignored entirely, and the controller waits indefinitely for the remaining bytes.

## Structure
- Package uart_cmd_pkg holds:
  - the state enum (IDLE, LEN, WDATA, RD_REQ, RD_WAIT, TX_WAIT, TX_GUARD)
  - CMD_RD_BIT = 7
  - the RD_LAT legal-range constants
- Sub-module uart_cmd_rdlat: an RD_LAT-deep shift register of the reg_read strobe, producing the capture-enable pulse.

## Test plan
- Write: bytes 0x05, 0x02, 0xAA, 0x55 → two reg_write pulses:
  - addr 5, idx 0, wdata 0xAA
  - addr 5, idx 1, wdata 0x55
  - busy low afterwards, err never pulses.
- Read with tx_busy held low, reg_rdata = 0x3C: bytes 0x83, 0x03 → three reg_read pulses with addr 3 and idx 0, 1, 2; three tx_start pulses with tx_data 0x3C; spacing 3+RD_LAT cycles.
- Read backpressure: tx_busy high for 100 cycles after each tx_start → next reg_read is not issued until tx_busy falls; exactly LEN tx_start pulses in total.
- LEN = 0: bytes 0x01, 0x00 → no strobes, no tx_start, busy returns low 1 cycle after the LEN byte.
- Timeout (macro on): bytes 0x02, 0x04, 0x11, then rx_endofpacket → one reg_write, one err pulse, IDLE. A following write packet to addr 1 with LEN 1 executes normally.
- Reset mid-read: assert rst_n low in TX_WAIT → all outputs 0 immediately; after release, a new packet 0x81, 0x01 yields a single reg_read.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, command-byte read bit position, legal RD_LAT
// range and a helper that forces RD_LAT into that range.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        WDATA,
        RD_REQ,
        RD_WAIT,
        TX_WAIT,
        TX_GUARD
    } cmdState_t;

    localparam int CMD_RD_BIT = 7;
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // Out-of-range latencies are pulled to the nearest legal value so a bad
    // parameter cannot produce a zero-width or oversized capture pipeline.
    function automatic int clampRdLat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Bundle of UART receive/transmit and register-bus signals for the sequencer.
// Latency: n/a (wires only).
// Backpressure: tx_busy from the transmitter stalls transmit requests.
//
// master: the sequencer (drives register bus, tx request, busy, err).
// slave : the environment (UART receiver/transmitter and register file).
interface uart_cmd_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              rx_data_ready;
    logic [7:0]        rx_data;
    logic              rx_endofpacket;
    logic [ADDR_W-1:0] reg_addr;
    logic [7:0]        reg_idx;
    logic [7:0]        reg_wdata;
    logic              reg_write;
    logic              reg_read;
    logic [7:0]        reg_rdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              busy;
    logic              err;

    modport master (
        input  rx_data_ready, rx_data, rx_endofpacket, reg_rdata, tx_busy,
        output reg_addr, reg_idx, reg_wdata, reg_write, reg_read,
               tx_data, tx_start, busy, err
    );

    modport slave (
        output rx_data_ready, rx_data, rx_endofpacket, reg_rdata, tx_busy,
        input  reg_addr, reg_idx, reg_wdata, reg_write, reg_read,
               tx_data, tx_start, busy, err
    );
endinterface

// File: rtl/uart_cmd_rdlat.sv
// Delays the register read strobe to mark the cycle in which read data is valid.
// Latency: captureEn is high exactly RD_LAT cycles after readStrobe.
// Backpressure: none; strobes are never stalled or dropped.
//
// Ports: clk, rst_n (async active-low), readStrobe (reg_read pulse),
//        captureEn (one-cycle pulse aligned with valid reg_rdata).
module uart_cmd_rdlat #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic readStrobe,
    output logic captureEn
);
    logic [RD_LAT-1:0] pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            // Shift-left form stays legal for RD_LAT = 1.
            pipe <= (pipe << 1) | RD_LAT'(readStrobe);
        end
    end

    assign captureEn = pipe[RD_LAT-1];
endmodule

// File: rtl/uart_cmd_sequencer.sv
// Parses CMD/LEN/payload bytes from the UART and sequences register writes or reads+transmits.
// Latency: reg_write one cycle after the rx byte; tx_start RD_LAT+2 cycles after reg_read when tx is free.
// Backpressure: waits in TX_WAIT while tx_busy is high; rx bytes during a read are dropped with err.
//
// Ports: clk, rst_n (async active-low); bus (uart_cmd_sequencer_if.master):
//   rx_data_ready/rx_data/rx_endofpacket in, reg_addr/reg_idx/reg_wdata/reg_write/reg_read out,
//   reg_rdata in, tx_data/tx_start out, tx_busy in, busy/err out.
// Build option: define UART_CMD_TIMEOUT_EN to abort an incomplete write packet on
// rx_endofpacket; without it rx_endofpacket is ignored.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    uart_cmd_sequencer_if.master bus
);
    localparam int LAT = clampRdLat(RD_LAT);

    cmdState_t         state, stateNext;
    logic [7:0]        count, countNext;
    logic              isRead, isReadNext;
    logic [ADDR_W-1:0] regAddr, regAddrNext;
    logic [7:0]        regIdx, regIdxNext;
    logic [7:0]        regWdata, regWdataNext;
    logic [7:0]        txData, txDataNext;
    logic              regWrite, regWriteNext;
    logic              regRead, regReadNext;
    logic              txStart, txStartNext;
    logic              errPulse, errNext;
    logic              captureEn;
    logic              rxVld;
    logic              eopAbort;

    assign rxVld = bus.rx_data_ready;

`ifdef UART_CMD_TIMEOUT_EN
    // A data byte in the same cycle wins over end-of-packet.
    assign eopAbort = bus.rx_endofpacket && !bus.rx_data_ready;
`else
    logic unusedEop;
    assign unusedEop = bus.rx_endofpacket;
    assign eopAbort  = 1'b0;
`endif

    uart_cmd_rdlat #(
        .RD_LAT(LAT)
    ) uRdLat (
        .clk       (clk),
        .rst_n     (rst_n),
        .readStrobe(regRead),
        .captureEn (captureEn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            count    <= '0;
            isRead   <= 1'b0;
            regAddr  <= '0;
            regIdx   <= '0;
            regWdata <= '0;
            txData   <= '0;
            regWrite <= 1'b0;
            regRead  <= 1'b0;
            txStart  <= 1'b0;
            errPulse <= 1'b0;
        end else begin
            state    <= stateNext;
            count    <= countNext;
            isRead   <= isReadNext;
            regAddr  <= regAddrNext;
            regIdx   <= regIdxNext;
            regWdata <= regWdataNext;
            txData   <= txDataNext;
            regWrite <= regWriteNext;
            regRead  <= regReadNext;
            txStart  <= txStartNext;
            errPulse <= errNext;
        end
    end

    always_comb begin
        stateNext    = state;
        countNext    = count;
        isReadNext   = isRead;
        regAddrNext  = regAddr;
        // reg_idx must show the current byte index while reg_write is high,
        // so the write-side increment is applied the cycle after the strobe.
        regIdxNext   = regWrite ? regIdx + 8'd1 : regIdx;
        regWdataNext = regWdata;
        txDataNext   = txData;
        regWriteNext = 1'b0;
        regReadNext  = 1'b0;
        txStartNext  = 1'b0;
        errNext      = 1'b0;

        // The host must not send while a read is in flight; drop and flag.
        if (rxVld && (state inside {RD_REQ, RD_WAIT, TX_WAIT, TX_GUARD})) begin
            errNext = 1'b1;
        end

        unique case (state)
            IDLE: begin
                if (rxVld) begin
                    regAddrNext = bus.rx_data[ADDR_W-1:0];
                    isReadNext  = bus.rx_data[CMD_RD_BIT];
                    stateNext   = LEN;
                end
            end
            LEN: begin
                if (rxVld) begin
                    countNext  = bus.rx_data;
                    regIdxNext = 8'd0;
                    if (bus.rx_data == 8'd0) begin
                        stateNext = IDLE;
                    end else if (isRead) begin
                        // Strobe is registered so it is high during RD_REQ.
                        stateNext   = RD_REQ;
                        regReadNext = 1'b1;
                    end else begin
                        stateNext = WDATA;
                    end
                end else if (eopAbort) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end
            end
            WDATA: begin
                if (rxVld) begin
                    regWriteNext = 1'b1;
                    regWdataNext = bus.rx_data;
                    countNext    = count - 8'd1;
                    if (count == 8'd1) begin
                        stateNext = IDLE;
                    end
                end else if (eopAbort && count != 8'd0) begin
                    stateNext = IDLE;
                    errNext   = 1'b1;
                end
            end
            RD_REQ: begin
                stateNext = RD_WAIT;
            end
            RD_WAIT: begin
                if (captureEn) begin
                    txDataNext = bus.reg_rdata;
                    stateNext  = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (!bus.tx_busy) begin
                    txStartNext = 1'b1;
                    stateNext   = TX_GUARD;
                end
            end
            TX_GUARD: begin
                // tx_busy may only rise now, so it is not looked at here.
                countNext  = count - 8'd1;
                regIdxNext = regIdx + 8'd1;
                if (count == 8'd1) begin
                    stateNext = IDLE;
                end else begin
                    stateNext   = RD_REQ;
                    regReadNext = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.reg_addr  = regAddr;
    assign bus.reg_idx   = regIdx;
    assign bus.reg_wdata = regWdata;
    assign bus.reg_write = regWrite;
    assign bus.reg_read  = regRead;
    assign bus.tx_data   = txData;
    assign bus.tx_start  = txStart;
    assign bus.busy      = (state != IDLE);
    assign bus.err       = errPulse;
endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Directed bench for uart_cmd_sequencer with a queue-based expectation model.
// Latency: n/a.
// Backpressure: bench emulates tx_busy hold-off and a fixed-latency register file.
module tb_uart_cmd_sequencer;
    localparam int ADDR_W = 6;
    localparam int RD_LAT = 2;
    localparam int AMASK  = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_cmd_sequencer_if #(.ADDR_W(ADDR_W)) bus();

    uart_cmd_sequencer #(
        .ADDR_W(ADDR_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct { int addr; int idx; int data; int cyc; } wExp_t;
    typedef struct { int addr; int idx; int data; } rExp_t;

    wExp_t expW[$];
    rExp_t expR[$];
    int    expT[$];
    int    wLog[$];
    int    tLog[$];
    int    dq[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int expErr = 0, errSeen = 0;
    int wCnt = 0, rCnt = 0, tCnt = 0;
    int rdDue = -1, rdVal = 0;
    int lastRdCyc = -1, lastTxCyc = -1;
    int busyFrom = -1, busyUntil = -1;
    bit constRd = 1'b0, exactSpacing = 1'b0, holdBusy = 1'b0, forceBusy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Register file contents as seen by the host: a fixed function of (addr, idx).
    function automatic int rdFunc(input int addr, input int idx);
        if (constRd) return 'h3C;
        return (addr * 16 + idx * 5 + 7) & 255;
    endfunction

    // Compare process: checks strobes against the expectation queues and
    // plays the register file and transmitter for the rest of the cycle.
    wExp_t we;
    rExp_t re;
    int    te;
    initial begin
        bus.reg_rdata = 8'hEE;
        bus.tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.reg_write === 1'b1) begin
                wCnt++;
                wLog.push_back(int'(bus.reg_wdata));
                if (expW.size() == 0) check("unexpected reg_write", 1, 0);
                else begin
                    we = expW.pop_front();
                    check("wr addr", int'(bus.reg_addr), we.addr);
                    check("wr idx", int'(bus.reg_idx), we.idx);
                    check("wr data", int'(bus.reg_wdata), we.data);
                    check("wr cycle", cyc, we.cyc);
                end
            end
            if (bus.reg_read === 1'b1) begin
                rCnt++;
                check("read at most one ahead of tx", int'((rCnt - tCnt) <= 1), 1);
                if (expR.size() == 0) check("unexpected reg_read", 1, 0);
                else begin
                    re = expR.pop_front();
                    check("rd addr", int'(bus.reg_addr), re.addr);
                    check("rd idx", int'(bus.reg_idx), re.idx);
                    rdDue = cyc + RD_LAT;
                    rdVal = re.data;
                end
                lastRdCyc = cyc;
            end
            if (bus.tx_start === 1'b1) begin
                tCnt++;
                tLog.push_back(int'(bus.tx_data));
                if (expT.size() == 0) check("unexpected tx_start", 1, 0);
                else begin
                    te = expT.pop_front();
                    check("tx data", int'(bus.tx_data), te);
                end
                check("tx_busy low before tx_start", int'(bus.tx_busy), 0);
                check("tx not before read+lat+1", int'((cyc - lastRdCyc) >= RD_LAT + 1), 1);
                if (exactSpacing && lastTxCyc >= 0)
                    check("tx spacing", cyc - lastTxCyc, 3 + RD_LAT);
                lastTxCyc = cyc;
                if (holdBusy) begin
                    busyFrom  = cyc;
                    busyUntil = cyc + 100;
                end
            end
            if (bus.err === 1'b1) errSeen++;
            bus.tx_busy   = forceBusy || (cyc > busyFrom && cyc <= busyUntil);
            bus.reg_rdata = (cyc == rdDue) ? 8'(rdVal) : 8'hEE;
        end
    end

    task automatic drive(input logic [7:0] b, input bit eop, input bit vld, input int gap, output int bc);
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        bus.rx_data        = b;
        bus.rx_data_ready  = vld;
        bus.rx_endofpacket = eop;
        bc = cyc;
        @(posedge clk);
        #1;
        bus.rx_data_ready  = 1'b0;
        bus.rx_endofpacket = 1'b0;
    endtask

    task automatic writePkt(input int cmd, input int gap, input bit b2b, input bit eopOnData);
        int bc;
        drive(8'(cmd), 1'b0, 1'b1, gap, bc);
        drive(8'(dq.size()), 1'b0, 1'b1, gap, bc);
        for (int i = 0; i < dq.size(); i++) begin
            drive(8'(dq[i]), eopOnData, 1'b1, b2b ? 0 : gap, bc);
            expW.push_back('{cmd & AMASK, i, dq[i], bc + 1});
        end
    endtask

    task automatic readPkt(input int cmd, input int len);
        int bc;
        drive(8'(cmd), 1'b0, 1'b1, 2, bc);
        drive(8'(len), 1'b0, 1'b1, 2, bc);
        for (int i = 0; i < len; i++) begin
            expR.push_back('{cmd & AMASK, i, rdFunc(cmd & AMASK, i)});
            expT.push_back(rdFunc(cmd & AMASK, i));
        end
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        @(negedge clk);
        while (bus.busy === 1'b1 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("returned to idle", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic newTest();
        wCnt = 0; rCnt = 0; tCnt = 0;
        wLog.delete(); tLog.delete();
        lastTxCyc = -1; lastRdCyc = -1;
    endtask

    task automatic endCheck();
        check("writes outstanding", expW.size(), 0);
        check("reads outstanding", expR.size(), 0);
        check("tx outstanding", expT.size(), 0);
        check("err pulses", errSeen, expErr);
    endtask

    task automatic checkAllZero();
        check("rst reg_addr", int'(bus.reg_addr), 0);
        check("rst reg_idx", int'(bus.reg_idx), 0);
        check("rst reg_wdata", int'(bus.reg_wdata), 0);
        check("rst reg_write", int'(bus.reg_write), 0);
        check("rst reg_read", int'(bus.reg_read), 0);
        check("rst tx_data", int'(bus.tx_data), 0);
        check("rst tx_start", int'(bus.tx_start), 0);
        check("rst busy", int'(bus.busy), 0);
        check("rst err", int'(bus.err), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

    int bc;
    int n;
    initial begin
        bus.rx_data_ready  = 1'b0;
        bus.rx_data        = 8'h00;
        bus.rx_endofpacket = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Simple write, spaced bytes.
        newTest();
        dq = '{'hAA, 'h55};
        writePkt('h05, 3, 1'b0, 1'b0);
        waitIdle(200);
        check("t1 write count", wCnt, 2);
        check("t1 first wdata", wLog[0], 'hAA);
        check("t1 second wdata", wLog[1], 'h55);
        endCheck();

        // Read, tx always free, plus one stray byte during the read.
        newTest();
        constRd = 1'b1;
        exactSpacing = 1'b1;
        readPkt('h83, 3);
        drive(8'h99, 1'b0, 1'b1, 4, bc);
        expErr++;
        waitIdle(200);
        check("t2 read count", rCnt, 3);
        check("t2 tx count", tCnt, 3);
        check("t2 tx byte 2", tLog[2], 'h3C);
        endCheck();
        exactSpacing = 1'b0;
        constRd = 1'b0;

        // Read with transmitter backpressure; reserved CMD bit 6 set.
        newTest();
        holdBusy = 1'b1;
        readPkt('hC7, 3);
        waitIdle(1000);
        check("t3 tx count", tCnt, 3);
        check("t3 tx byte 0", tLog[0], 'h77);
        check("t3 tx byte 1", tLog[1], 'h7C);
        check("t3 tx byte 2", tLog[2], 'h81);
        endCheck();
        holdBusy = 1'b0;
        repeat (110) @(negedge clk);

        // Back-to-back payload bytes, reserved bit set on a write.
        newTest();
        dq = '{1, 2, 3};
        writePkt('h6A, 2, 1'b1, 1'b0);
        waitIdle(200);
        check("t4 write count", wCnt, 3);
        endCheck();

        // LEN = 0 for write and read.
        newTest();
        drive(8'h01, 1'b0, 1'b1, 2, bc);
        check("t5 busy after cmd", int'(bus.busy), 1);
        drive(8'h00, 1'b0, 1'b1, 1, bc);
        check("t5 busy after len0", int'(bus.busy), 0);
        readPkt('h81, 0);
        check("t5 busy after rd len0", int'(bus.busy), 0);
        repeat (10) @(negedge clk);
        check("t5 strobes", wCnt + rCnt + tCnt, 0);
        endCheck();

        // End-of-packet in the middle of a write.
        newTest();
        drive(8'h02, 1'b0, 1'b1, 2, bc);
        drive(8'h04, 1'b0, 1'b1, 2, bc);
        drive(8'h11, 1'b0, 1'b1, 2, bc);
        expW.push_back('{2, 0, 'h11, bc + 1});
        drive(8'h00, 1'b1, 1'b0, 3, bc);
`ifdef UART_CMD_TIMEOUT_EN
        expErr++;
        check("t6 aborted to idle", int'(bus.busy), 0);
`else
        check("t6 still waiting", int'(bus.busy), 1);
        for (int i = 1; i < 4; i++) begin
            drive(8'(i * 'h11 + 'h11), 1'b0, 1'b1, 2, bc);
            expW.push_back('{2, i, i * 'h11 + 'h11, bc + 1});
        end
`endif
        dq = '{'h5A};
        writePkt('h01, 2, 1'b0, 1'b1);
        waitIdle(200);
`ifdef UART_CMD_TIMEOUT_EN
        check("t6 write count", wCnt, 2);
`else
        check("t6 write count", wCnt, 5);
`endif
        check("t6 last wdata", wLog[wLog.size() - 1], 'h5A);
        endCheck();

        // Reset while waiting for the transmitter.
        newTest();
        forceBusy = 1'b1;
        readPkt('h83, 2);
        n = 0;
        while (rCnt < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t7 first read issued", rCnt, 1);
        repeat (4) @(negedge clk);
        check("t7 waiting on tx", int'(bus.busy), 1);
        #1 rst_n = 1'b0;
        #1;
        checkAllZero();
        check("t7 no tx before reset", expT.size(), 2);
        check("t7 reads left", expR.size(), 1);
        expT.delete();
        expR.delete();
        rdDue = -1;
        forceBusy = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        newTest();
        readPkt('h81, 1);
        waitIdle(200);
        check("t7 read count", rCnt, 1);
        check("t7 tx count", tCnt, 1);
        check("t7 tx byte", tLog[0], 'h17);
        endCheck();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
